// File: rtl/unidad_de_extension_reg.sv
// Immediate-extension unit: 24-bit sign extension or ARM rotated 8-bit immediate,
// registered onto a 32-bit operand for the ALU source-B / branch-target mux.
module unidad_de_extension_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] dataI,
  input  logic        ExtImm,
  output logic [31:0] dataO
);

  function automatic logic [31:0] signExtend(input logic [23:0] value);
    return {{8{value[23]}}, value};
  endfunction

  // Logarithmic barrel rotate-right: stage k rotates by 2**k when amount[k] is set.
  function automatic logic [31:0] rotateRight(input logic [31:0] value, input logic [4:0] amount);
    logic [31:0] stage;
    stage = value;
    if (amount[0]) stage = {stage[0],     stage[31:1]};  else stage = stage;
    if (amount[1]) stage = {stage[1:0],   stage[31:2]};  else stage = stage;
    if (amount[2]) stage = {stage[3:0],   stage[31:4]};  else stage = stage;
    if (amount[3]) stage = {stage[7:0],   stage[31:8]};  else stage = stage;
    if (amount[4]) stage = {stage[15:0],  stage[31:16]}; else stage = stage;
    return stage;
  endfunction

  logic [4:0]  rotAmount_s;
  logic [31:0] rotImm_s;
  logic [31:0] extImm_s;
  logic [31:0] nextValue_s;

  // Build both candidate operands and select by mode; rotation is twice the 4-bit field.
  always_comb begin
    rotAmount_s = {dataI[11:8], 1'b0};
    rotImm_s    = rotateRight({24'h00_0000, dataI[7:0]}, rotAmount_s);
    extImm_s    = signExtend(dataI);
    nextValue_s = 32'h0000_0000;
    case (ExtImm)
      1'b1:    nextValue_s = extImm_s;
      1'b0:    nextValue_s = rotImm_s;
      default: nextValue_s = 32'h0000_0000;
    endcase
  end

  // Output register loads every cycle; reset has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataO <= 32'h0000_0000;
    end else begin
      dataO <= nextValue_s;
    end
  end

endmodule

// File: tb/tb_unidad_de_extension_reg.sv
// Self-checking bench: directed literal checks plus randomized stimulus against
// an arithmetic reference model, compared on every falling edge.
module tb_unidad_de_extension_reg;

  logic        clk;
  logic        reset;
  logic [23:0] dataI;
  logic        ExtImm;
  logic [31:0] dataO;

  int checks;
  int passes;
  logic        modelValid;
  logic [31:0] expected;

  unidad_de_extension_reg dut (
    .clk    (clk),
    .reset  (reset),
    .dataI  (dataI),
    .ExtImm (ExtImm),
    .dataO  (dataO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign extension via signed integer, rotation via a doubled 64-bit word shifted right.
  function automatic logic [31:0] refExt(input logic [23:0] d, input logic m);
    int          sval;
    logic [63:0] dbl;
    int          amt;
    if (m) begin
      sval = int'($signed(d));
      return 32'(sval);
    end else begin
      dbl = {24'd0, d[7:0], 24'd0, d[7:0]};
      amt = 2 * int'(d[11:8]);
      return dbl[31:0] == 32'd0 ? 32'd0 : 32'(dbl >> amt);
    end
  endfunction

  initial begin
    modelValid = 1'b0;
    expected   = 32'd0;
  end

  always @(posedge clk) begin
    expected   = reset ? 32'd0 : refExt(dataI, ExtImm);
    modelValid = 1'b1;
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checks++;
      if (dataO === expected) passes++;
      else $display("FAIL model dataO=%h expected=%h", dataO, expected);
    end
  end

  task automatic step(input logic r, input logic [23:0] d, input logic m,
                      input logic [31:0] lit, input string name);
    logic [31:0] mv;
    #1;
    reset  = r;
    dataI  = d;
    ExtImm = m;
    mv = r ? 32'd0 : refExt(d, m);
    @(negedge clk);
    checks++;
    if (dataO === lit) passes++;
    else $display("FAIL %s dataO=%h expected=%h", name, dataO, lit);
    checks++;
    if (mv === lit) passes++;
    else $display("FAIL %s_ref model=%h expected=%h", name, mv, lit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    passes = 0;
    reset  = 1'b1;
    dataI  = 24'hFF_FFFF;
    ExtImm = 1'b1;
    @(negedge clk);
    step(1'b1, 24'hFF_FFFF, 1'b1, 32'h0000_0000, "reset0");
    step(1'b1, 24'hFF_FFFF, 1'b1, 32'h0000_0000, "reset1");
    step(1'b0, 24'hFF_FFFF, 1'b1, 32'hFFFF_FFFF, "release");

    step(1'b0, 24'd0,       1'b1, 32'h0000_0000, "sx_zero");
    step(1'b0, 24'd543,     1'b1, 32'h0000_021F, "sx_543");
    step(1'b0, 24'd3,       1'b1, 32'h0000_0003, "sx_3");
    step(1'b0, 24'd1,       1'b1, 32'h0000_0001, "sx_1");
    step(1'b0, 24'hFF_FDE1, 1'b1, 32'hFFFF_FDE1, "sx_m543");
    step(1'b0, 24'hFF_FFFF, 1'b1, 32'hFFFF_FFFF, "sx_m1");
    step(1'b0, 24'h80_0000, 1'b1, 32'hFF80_0000, "sx_min");
    step(1'b0, 24'h7F_FFFF, 1'b1, 32'h007F_FFFF, "sx_max");

    step(1'b0, 24'h00_00FF, 1'b0, 32'h0000_00FF, "rot0");
    step(1'b0, 24'h00_04FF, 1'b0, 32'hFF00_0000, "rot4");
    step(1'b0, 24'h00_0F01, 1'b0, 32'h0000_0004, "rot15");
    step(1'b0, 24'hAB_C104, 1'b0, 32'h0000_0001, "rot1_upper");

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 24'hFF_FF80, 1'b1, 32'hFFFF_FF80, "alt_sx");
      step(1'b0, 24'hFF_FF80, 1'b0, 32'h0000_0200, "alt_rot");
    end

    step(1'b0, 24'h00_0123, 1'b1, 32'h0000_0123, "pre_rst");
    step(1'b1, 24'h00_0456, 1'b1, 32'h0000_0000, "mid_rst");
    step(1'b0, 24'h00_0789, 1'b1, 32'h0000_0789, "post_rst");

    // Randomized stimulus; the falling-edge comparator checks each cycle against the model.
    for (int i = 0; i < 400; i++) begin
      #1;
      reset  = ($urandom_range(0, 19) == 0);
      dataI  = 24'($urandom);
      ExtImm = 1'($urandom);
      @(negedge clk);
    end

    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
